// File: rtl/dlx_pkg.sv
`default_nettype none
// dlx_pkg: shared opcode, forwarding and multiplier-state types for the DLX execute stage.
package dlx_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_t;

  // MEM is younger than WB, so it wins; register 0 is hard-wired and never forwards.
  function automatic fwd_sel_t fwd_select(input logic [REG_IDX_W-1:0] rs,
                                          input logic [REG_IDX_W-1:0] rd_mem,
                                          input logic [REG_IDX_W-1:0] rd_wb);
    if (rs != '0 && rs == rd_mem) return FWD_MEM;
    if (rs != '0 && rs == rd_wb)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mul_iter.sv
`default_nettype none
// ex_mul_iter: iterative shift-add multiplier, MUL_BITS multiplier bits per cycle.
module ex_mul_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import dlx_pkg::*;

  localparam int N_IT  = XLEN / MUL_BITS;
  localparam int CNT_W = (N_IT > 1) ? $clog2(N_IT) : 1;

  mul_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  a_sh;
  logic [XLEN-1:0]  b_sh;
  logic [XLEN-1:0]  partial;
  logic [XLEN-1:0]  acc_next;

  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (b_sh[j]) partial = partial + (a_sh << j);
    end
  end

  assign acc_next = acc + partial;
  assign busy     = (state == MUL_BUSY);
  assign done     = busy && (cnt == CNT_W'(N_IT - 1));
  // The final product is the accumulator after the last iteration, so present it combinationally.
  assign result   = acc_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= MUL_IDLE;
      cnt   <= '0;
      acc   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            acc   <= '0;
            cnt   <= '0;
            state <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          acc  <= acc_next;
          a_sh <= a_sh << MUL_BITS;
          b_sh <= b_sh >> MUL_BITS;
          cnt  <= cnt + 1'b1;
          if (done) state <= MUL_IDLE;
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ex_stage: DLX execute stage with MEM/WB forwarding, ALU, iterative MUL and EX/MEM registers.
module ex_stage #(
  parameter int XLEN     = dlx_pkg::XLEN,
  parameter int MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_EX,
  input  logic [3:0]      alu_op_EX,
  input  logic [XLEN-1:0] S1_EX,
  input  logic [XLEN-1:0] S2_EX,
  input  logic [4:0]      Rs1_EX,
  input  logic [4:0]      Rs2_EX,
  input  logic [XLEN-1:0] imm_EX,
  input  logic            use_imm_EX,
  input  logic [4:0]      Rd_EX,
  input  logic            d_write_enable_EX,
  input  logic            d_load_enable_EX,
  input  logic [XLEN-1:0] ALU_out_MEM_backward,
  input  logic [4:0]      Rd_MEM_backward,
  input  logic [XLEN-1:0] WB_data_backward,
  input  logic [4:0]      Rd_WB_backward,
  output logic            stall_EX,
  output logic [XLEN-1:0] ALU_out_MEM,
  output logic [XLEN-1:0] S3_MEM,
  output logic            d_write_enable_MEM,
  output logic            d_load_enable_MEM,
  output logic [4:0]      Rd_MEM
);
  import dlx_pkg::*;

  localparam int SHAMT_W = $clog2(XLEN);

  alu_op_t              op;
  fwd_sel_t             sel_a;
  fwd_sel_t             sel_b;
  logic [XLEN-1:0]      fwd_a;
  logic [XLEN-1:0]      fwd_b;
  logic [XLEN-1:0]      op_b;
  logic [SHAMT_W-1:0]   shamt;
  logic [XLEN-1:0]      alu_res;
  logic                 is_mul;
  logic                 mul_start;
  logic                 mul_busy;
  logic                 mul_done;
  logic [XLEN-1:0]      mul_result;
  logic [REG_IDX_W-1:0] rd_mul;

  assign op    = alu_op_t'(alu_op_EX);
  assign sel_a = fwd_select(Rs1_EX, Rd_MEM_backward, Rd_WB_backward);
  assign sel_b = fwd_select(Rs2_EX, Rd_MEM_backward, Rd_WB_backward);

  always_comb begin
    case (sel_a)
      FWD_MEM: fwd_a = ALU_out_MEM_backward;
      FWD_WB:  fwd_a = WB_data_backward;
      default: fwd_a = S1_EX;
    endcase
    case (sel_b)
      FWD_MEM: fwd_b = ALU_out_MEM_backward;
      FWD_WB:  fwd_b = WB_data_backward;
      default: fwd_b = S2_EX;
    endcase
  end

  assign op_b  = use_imm_EX ? imm_EX : fwd_b;
  assign shamt = op_b[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD:  alu_res = fwd_a + op_b;
      ALU_SUB:  alu_res = fwd_a - op_b;
      ALU_AND:  alu_res = fwd_a & op_b;
      ALU_OR:   alu_res = fwd_a | op_b;
      ALU_XOR:  alu_res = fwd_a ^ op_b;
      ALU_SLL:  alu_res = fwd_a << shamt;
      ALU_SRL:  alu_res = fwd_a >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(fwd_a) >>> shamt);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, fwd_a < op_b};
      default:  alu_res = '0;
    endcase
  end

  // A MUL is only accepted from idle; anything presented while busy is ignored.
  assign is_mul    = valid_EX && (op == ALU_MUL);
  assign mul_start = reset_n && is_mul && !mul_busy;
  assign stall_EX  = reset_n && (mul_start || (mul_busy && !mul_done));

  ex_mul_iter #(
    .XLEN     (XLEN),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (fwd_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .result  (mul_result)
  );

  always_ff @(posedge clk) begin
    if (!reset_n)       rd_mul <= '0;
    else if (mul_start) rd_mul <= Rd_EX;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ALU_out_MEM        <= '0;
      S3_MEM             <= '0;
      d_write_enable_MEM <= 1'b0;
      d_load_enable_MEM  <= 1'b0;
      Rd_MEM             <= '0;
    end else if (mul_done) begin
      ALU_out_MEM        <= mul_result;
      S3_MEM             <= '0;
      d_write_enable_MEM <= 1'b0;
      d_load_enable_MEM  <= 1'b0;
      Rd_MEM             <= rd_mul;
    end else if (stall_EX || mul_busy || !valid_EX) begin
      ALU_out_MEM        <= '0;
      S3_MEM             <= '0;
      d_write_enable_MEM <= 1'b0;
      d_load_enable_MEM  <= 1'b0;
      Rd_MEM             <= '0;
    end else begin
      ALU_out_MEM        <= alu_res;
      S3_MEM             <= fwd_b;
      d_write_enable_MEM <= d_write_enable_EX;
      d_load_enable_MEM  <= d_load_enable_EX;
      Rd_MEM             <= Rd_EX;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// tb_ex_stage: directed self-checking bench for the DLX execute stage.
module tb_ex_stage;
  import dlx_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        valid_EX;
  logic [3:0]  alu_op_EX;
  logic [31:0] S1_EX, S2_EX, imm_EX;
  logic [4:0]  Rs1_EX, Rs2_EX, Rd_EX;
  logic        use_imm_EX, d_write_enable_EX, d_load_enable_EX;
  logic [31:0] ALU_out_MEM_backward, WB_data_backward;
  logic [4:0]  Rd_MEM_backward, Rd_WB_backward;
  logic        stall_EX;
  logic [31:0] ALU_out_MEM, S3_MEM;
  logic        d_write_enable_MEM, d_load_enable_MEM;
  logic [4:0]  Rd_MEM;

  int total = 0;
  int bad   = 0;

  ex_stage #(.XLEN(32), .MUL_BITS(1)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .valid_EX             (valid_EX),
    .alu_op_EX            (alu_op_EX),
    .S1_EX                (S1_EX),
    .S2_EX                (S2_EX),
    .Rs1_EX               (Rs1_EX),
    .Rs2_EX               (Rs2_EX),
    .imm_EX               (imm_EX),
    .use_imm_EX           (use_imm_EX),
    .Rd_EX                (Rd_EX),
    .d_write_enable_EX    (d_write_enable_EX),
    .d_load_enable_EX     (d_load_enable_EX),
    .ALU_out_MEM_backward (ALU_out_MEM_backward),
    .Rd_MEM_backward      (Rd_MEM_backward),
    .WB_data_backward     (WB_data_backward),
    .Rd_WB_backward       (Rd_WB_backward),
    .stall_EX             (stall_EX),
    .ALU_out_MEM          (ALU_out_MEM),
    .S3_MEM               (S3_MEM),
    .d_write_enable_MEM   (d_write_enable_MEM),
    .d_load_enable_MEM    (d_load_enable_MEM),
    .Rd_MEM               (Rd_MEM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                       input logic ui, input logic [4:0] rd, input logic we, input logic le);
    valid_EX = 1'b1; alu_op_EX = op; S1_EX = s1; S2_EX = s2; Rs1_EX = rs1; Rs2_EX = rs2;
    imm_EX = imm; use_imm_EX = ui; Rd_EX = rd; d_write_enable_EX = we; d_load_enable_EX = le;
    #1;
  endtask

  task automatic no_fwd();
    ALU_out_MEM_backward = 32'h0; Rd_MEM_backward = 5'd0;
    WB_data_backward = 32'h0; Rd_WB_backward = 5'd0;
  endtask

  int stall_err, bub_err, n, leak;

  initial begin
    reset_n = 1'b0; valid_EX = 1'b0; alu_op_EX = 4'd0; S1_EX = '0; S2_EX = '0;
    Rs1_EX = '0; Rs2_EX = '0; imm_EX = '0; use_imm_EX = 1'b0; Rd_EX = '0;
    d_write_enable_EX = 1'b0; d_load_enable_EX = 1'b0;
    no_fwd();
    repeat (2) tick();
    reset_n = 1'b1;

    // Mid-stream reset: one ADD in flight, then reset held 2 cycles with a MUL presented
    issue(ALU_ADD, 32'd1, 32'd2, 5'd1, 5'd2, 32'd0, 1'b0, 5'd5, 1'b0, 1'b0);
    tick();
    chk("pre_reset_add", ALU_out_MEM, 32'd3);
    chk("pre_reset_rd", {27'd0, Rd_MEM}, 32'd5);
    issue(ALU_MUL, 32'd3, 32'd3, 5'd1, 5'd2, 32'd0, 1'b0, 5'd7, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("stall_in_reset", {31'd0, stall_EX}, 32'd0);
    tick(); tick();
    chk("rst_alu", ALU_out_MEM, 32'd0);
    chk("rst_s3", S3_MEM, 32'd0);
    chk("rst_we_le_rd", {25'd0, d_write_enable_MEM, d_load_enable_MEM, Rd_MEM}, 32'd0);
    reset_n = 1'b1; valid_EX = 1'b0;
    #1;
    chk("post_rst_stall", {31'd0, stall_EX}, 32'd0);
    tick();
    chk("post_rst_rd", {27'd0, Rd_MEM}, 32'd0);

    // ALU ops
    issue(ALU_ADD, 32'd5, 32'hFFFF_FFFF, 5'd1, 5'd2, 32'd0, 1'b0, 5'd4, 1'b0, 1'b0);
    chk("add_stall", {31'd0, stall_EX}, 32'd0);
    tick();
    chk("add_wrap", ALU_out_MEM, 32'd4);
    chk("add_rd", {27'd0, Rd_MEM}, 32'd4);
    issue(ALU_SRA, 32'h8000_0000, 32'd0, 5'd1, 5'd2, 32'd4, 1'b1, 5'd6, 1'b0, 1'b0);
    tick();
    chk("sra", ALU_out_MEM, 32'hF800_0000);
    issue(ALU_SRL, 32'h8000_0000, 32'd4, 5'd1, 5'd2, 32'd0, 1'b0, 5'd6, 1'b0, 1'b0);
    tick();
    chk("srl", ALU_out_MEM, 32'h0800_0000);
    issue(ALU_SLL, 32'h0000_0003, 32'h0000_0024, 5'd1, 5'd2, 32'd0, 1'b0, 5'd6, 1'b0, 1'b0);
    tick();
    chk("sll_b40", ALU_out_MEM, 32'h0000_0030);
    issue(ALU_SUB, 32'd3, 32'd5, 5'd1, 5'd2, 32'd0, 1'b0, 5'd6, 1'b0, 1'b0);
    tick();
    chk("sub", ALU_out_MEM, 32'hFFFF_FFFE);
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd1, 5'd2, 32'd0, 1'b0, 5'd6, 1'b0, 1'b0);
    tick();
    chk("slt", ALU_out_MEM, 32'd1);
    issue(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd1, 5'd2, 32'd0, 1'b0, 5'd6, 1'b0, 1'b0);
    tick();
    chk("sltu", ALU_out_MEM, 32'd0);
    issue(ALU_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd1, 5'd2, 32'd0, 1'b0, 5'd6, 1'b0, 1'b0);
    tick();
    chk("xor", ALU_out_MEM, 32'hFF00_EDCB);
    issue(4'd15, 32'd9, 32'd9, 5'd1, 5'd2, 32'd0, 1'b0, 5'd6, 1'b0, 1'b0);
    tick();
    chk("undef_op", ALU_out_MEM, 32'd0);

    // Forwarding priority
    ALU_out_MEM_backward = 32'h11; Rd_MEM_backward = 5'd3;
    WB_data_backward = 32'h22; Rd_WB_backward = 5'd3;
    issue(ALU_ADD, 32'h99, 32'd0, 5'd3, 5'd0, 32'd0, 1'b1, 5'd8, 1'b0, 1'b0);
    tick();
    chk("fwd_mem_wins", ALU_out_MEM, 32'h11);
    Rd_MEM_backward = 5'd3;
    issue(ALU_ADD, 32'h99, 32'd0, 5'd4, 5'd0, 32'd0, 1'b1, 5'd8, 1'b0, 1'b0);
    Rd_WB_backward = 5'd4;
    tick();
    chk("fwd_wb", ALU_out_MEM, 32'h22);
    Rd_MEM_backward = 5'd0; Rd_WB_backward = 5'd0;
    issue(ALU_ADD, 32'h55, 32'd0, 5'd0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b0, 1'b0);
    tick();
    chk("fwd_r0", ALU_out_MEM, 32'h55);

    // Store with WB-forwarded store data and immediate address offset
    no_fwd();
    WB_data_backward = 32'hCAFE; Rd_WB_backward = 5'd9;
    issue(ALU_ADD, 32'h100, 32'h1234, 5'd1, 5'd9, 32'd8, 1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    chk("st_addr", ALU_out_MEM, 32'h108);
    chk("st_data", S3_MEM, 32'hCAFE);
    chk("st_we_le_rd", {25'd0, d_write_enable_MEM, d_load_enable_MEM, Rd_MEM}, 32'h40);
    issue(ALU_ADD, 32'h200, 32'h1234, 5'd1, 5'd2, 32'd4, 1'b1, 5'd12, 1'b0, 1'b1);
    tick();
    chk("ld_we_le_rd", {25'd0, d_write_enable_MEM, d_load_enable_MEM, Rd_MEM}, 32'h2C);
    valid_EX = 1'b0;
    tick();
    chk("bubble_rd", {27'd0, Rd_MEM}, 32'd0);

    // MUL 7 * -3 with garbage presented and a conflicting writeback during BUSY
    no_fwd();
    issue(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 5'd2, 32'd0, 1'b0, 5'd10, 1'b0, 1'b0);
    stall_err = 0; bub_err = 0;
    for (int i = 0; i < 32; i++) begin
      if (stall_EX !== 1'b1) stall_err++;
      tick();
      if (Rd_MEM !== 5'd0 || ALU_out_MEM !== 32'd0) bub_err++;
      if (i == 0) begin
        issue(ALU_ADD, 32'h1000, 32'h1, 5'd1, 5'd2, 32'd0, 1'b0, 5'd20, 1'b1, 1'b0);
        WB_data_backward = 32'hDEAD; Rd_WB_backward = 5'd1;
      end
    end
    chk("mul_stall_32", stall_err, 0);
    chk("mul_bubbles", bub_err, 0);
    chk("mul_final_stall", {31'd0, stall_EX}, 32'd0);
    tick();
    chk("mul_result", ALU_out_MEM, 32'hFFFF_FFEB);
    chk("mul_rd", {27'd0, Rd_MEM}, 32'd10);
    chk("mul_we", {31'd0, d_write_enable_MEM}, 32'd0);
    no_fwd();
    issue(ALU_ADD, 32'd2, 32'd3, 5'd1, 5'd2, 32'd0, 1'b0, 5'd11, 1'b0, 1'b0);
    chk("after_mul_stall", {31'd0, stall_EX}, 32'd0);
    tick();
    chk("after_mul_add", ALU_out_MEM, 32'd5);
    chk("after_mul_rd", {27'd0, Rd_MEM}, 32'd11);

    // Reset aborts a MUL at cnt=10; then MUL 6*6
    issue(ALU_MUL, 32'd5, 32'd5, 5'd1, 5'd2, 32'd0, 1'b0, 5'd12, 1'b0, 1'b0);
    tick();
    valid_EX = 1'b0;
    repeat (10) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    chk("abort_stall", {31'd0, stall_EX}, 32'd0);
    leak = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Rd_MEM !== 5'd0 || ALU_out_MEM !== 32'd0 || stall_EX !== 1'b0) leak++;
    end
    chk("abort_no_result", leak, 0);
    issue(ALU_MUL, 32'd6, 32'd6, 5'd1, 5'd2, 32'd0, 1'b0, 5'd13, 1'b0, 1'b0);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) valid_EX = 1'b0;
    end while (Rd_MEM !== 5'd13 && n < 40);
    chk("mul2_latency", n, 33);
    chk("mul2_result", ALU_out_MEM, 32'd36);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
